// File: rtl/ame_det_arbiter.sv
// Round-robin front end sharing one determinant unit among REQ_NUM requesters.
// Tracks a 2-stage tag pipeline to route each completion back to its owner.
module ame_det_arbiter #(
  parameter int unsigned COMP_DATA_BITS = 64,
  parameter int unsigned REQ_NUM        = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [REQ_NUM-1:0]                            req_valid_i,
  input  logic [REQ_NUM-1:0][3:0][COMP_DATA_BITS-1:0]   req_data_i,
  output logic [REQ_NUM-1:0]                            req_ready_o,
  output logic [REQ_NUM-1:0]                            rsp_valid_o,
  output logic [REQ_NUM-1:0][COMP_DATA_BITS-1:0]        rsp_data_o,
  input  logic [REQ_NUM-1:0]                            rsp_ready_i,
  output logic                                          comp_init_o,
  output logic [3:0][COMP_DATA_BITS-1:0]                comp_data_o,
  input  logic                                          comp_done_i,
  input  logic [COMP_DATA_BITS-1:0]                     comp_data_i,
  output logic                                          err_o
);

  localparam int unsigned TAG_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  if (REQ_NUM < 2 || REQ_NUM > 8) begin : g_bad_req_num
    $error("ame_det_arbiter: REQ_NUM must be in 2..8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                                   state_q [REQ_NUM];
  state_t                                   state_d [REQ_NUM];
  logic [TAG_W-1:0]                         ptr_q, ptr_d;
  logic                                     s1_vld_q, s2_vld_q;
  logic [TAG_W-1:0]                         s1_tag_q, s2_tag_q;
  logic                                     rst_dly_q;

  logic [REQ_NUM-1:0]                       eligible;
  logic                                     grant_vld;
  logic [TAG_W-1:0]                         grant_tag;
  logic [TAG_W:0]                           sum;
  logic [TAG_W-1:0]                         idx;

  logic                                     done_ok;
  logic                                     capture;
  logic                                     missing;
  logic                                     spurious;
  logic                                     err_d;
  logic                                     comp_init_d;
  logic [3:0][COMP_DATA_BITS-1:0]           comp_data_d;
  logic [REQ_NUM-1:0]                       rsp_valid_d;
  logic [REQ_NUM-1:0][COMP_DATA_BITS-1:0]   rsp_data_d;

  // Round-robin search starting at ptr_q; reset suppresses every grant.
  always_comb begin
    eligible    = '0;
    grant_vld   = 1'b0;
    grant_tag   = '0;
    sum         = '0;
    idx         = '0;
    req_ready_o = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      eligible[k] = req_valid_i[k] && (state_q[k] == ST_IDLE) && !rst_i;
    end
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      sum = {1'b0, ptr_q} + (TAG_W+1)'(i);
      if (sum >= (TAG_W+1)'(REQ_NUM)) begin
        sum = sum - (TAG_W+1)'(REQ_NUM);
      end
      idx = sum[TAG_W-1:0];
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_tag = idx;
      end
    end
    if (grant_vld) begin
      req_ready_o[grant_tag] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_tag == TAG_W'(REQ_NUM - 1)) ? '0 : grant_tag + TAG_W'(1);
    end
  end

  // Completion classification; the first cycle after reset ignores comp_done_i.
  always_comb begin
    done_ok  = comp_done_i && !rst_dly_q;
    capture  = s2_vld_q && comp_done_i;
    missing  = s2_vld_q && !comp_done_i;
    spurious = done_ok && !s2_vld_q;
    err_d    = err_o || missing || spurious;
  end

  always_comb begin
    comp_init_d = grant_vld;
    comp_data_d = '0;
    if (grant_vld) begin
      comp_data_d = req_data_i[grant_tag];
    end
  end

  // Per-requester IDLE/BUSY/DONE next state and result capture.
  always_comb begin
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      state_d[k] = state_q[k];
    end
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_o;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      case (state_q[k])
        ST_IDLE: begin
          if (grant_vld && (grant_tag == TAG_W'(k))) begin
            state_d[k] = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s2_vld_q && (s2_tag_q == TAG_W'(k))) begin
            state_d[k] = capture ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          if (rsp_valid_o[k] && rsp_ready_i[k]) begin
            state_d[k] = ST_IDLE;
          end
        end
        default: state_d[k] = ST_IDLE;
      endcase
      rsp_valid_d[k] = (state_d[k] == ST_DONE);
      if (capture && (s2_tag_q == TAG_W'(k))) begin
        rsp_data_d[k] = comp_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
        state_q[k] <= ST_IDLE;
      end
      ptr_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_tag_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_tag_q    <= '0;
      rst_dly_q   <= 1'b1;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      comp_init_o <= 1'b0;
      comp_data_o <= '0;
      err_o       <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
        state_q[k] <= state_d[k];
      end
      ptr_q       <= ptr_d;
      s1_vld_q    <= grant_vld;
      s1_tag_q    <= grant_tag;
      s2_vld_q    <= s1_vld_q;
      s2_tag_q    <= s1_tag_q;
      rst_dly_q   <= 1'b0;
      rsp_valid_o <= rsp_valid_d;
      rsp_data_o  <= rsp_data_d;
      comp_init_o <= comp_init_d;
      comp_data_o <= comp_data_d;
      err_o       <= err_d;
    end
  end

endmodule

// File: tb/tb_ame_det_arbiter.sv
// Bench for ame_det_arbiter: directed cycle checks plus a per-requester result scoreboard.
// A behavioral determinant unit answers one cycle after each start pulse.
module tb_ame_det_arbiter;

  localparam int unsigned W = 64;
  localparam int unsigned N = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [N-1:0]             req_valid = '0;
  logic [N-1:0][3:0][W-1:0] req_data = '0;
  logic [N-1:0]             rdy;
  logic [N-1:0]             rsp_valid;
  logic [N-1:0][W-1:0]      rsp_data;
  logic [N-1:0]             rsp_ready = '1;
  logic                     comp_init;
  logic [3:0][W-1:0]        comp_data;
  logic                     comp_done;
  logic [W-1:0]             comp_res;
  logic                     err;

  logic                     unit_done;
  logic [W-1:0]             unit_res;
  logic                     spur_done = 1'b0;
  logic                     drop_done = 1'b0;

  logic [N-1:0]             rdy_s, rv_s;
  logic                     init_s, err_s;
  logic [3:0][W-1:0]        cdata_s;
  logic [N-1:0][W-1:0]      rdata_s;

  logic [W-1:0]             exp_q [N][$];
  int                       n_err = 0;
  int                       n_chk = 0;

  always #5 clk = ~clk;

  ame_det_arbiter #(.COMP_DATA_BITS(W), .REQ_NUM(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (rdy),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_ready_i (rsp_ready),
    .comp_init_o (comp_init),
    .comp_data_o (comp_data),
    .comp_done_i (comp_done),
    .comp_data_i (comp_res),
    .err_o       (err)
  );

  // Determinant unit model: M*D - L*C, answered one cycle after comp_init.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_done <= 1'b0;
      unit_res  <= '0;
    end else begin
      unit_done <= comp_init;
      unit_res  <= comp_data[3] * comp_data[2] - comp_data[1] * comp_data[0];
    end
  end
  assign comp_done = (unit_done & ~drop_done) | spur_done;
  assign comp_res  = unit_res;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] det(input logic [W-1:0] m, d, l, c);
    return m * d - l * c;
  endfunction

  // Scoreboard: every consumed result must match the oldest expected value for that requester.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(N); k++) begin
        if (rsp_valid[k] && rsp_ready[k]) begin
          if (exp_q[k].size() == 0) check($sformatf("unexpected_rsp%0d", k), 64'd1, 64'd0);
          else check($sformatf("rsp_data%0d", k), rsp_data[k], exp_q[k].pop_front());
        end
      end
    end
  end

  // One clock: snapshot outputs mid-cycle, then retire any accepted request.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc     = rdy;
    rdy_s   = rdy;
    rv_s    = rsp_valid;
    init_s  = comp_init;
    err_s   = err;
    cdata_s = comp_data;
    rdata_s = rsp_data;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic offer(input int k, input logic [W-1:0] m, d, l, c, input bit push);
    req_valid[k] = 1'b1;
    req_data[k]  = {m, d, l, c};
    if (push) exp_q[k].push_back(det(m, d, l, c));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    for (int k = 0; k < int'(N); k++) exp_q[k].delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    logic [N-1:0] e_rdy, e_rv;
    logic [W-1:0] first_val;

    // Reset: outputs low even with every requester asking.
    req_valid = '1;
    step();
    check("rst_ready", 64'(rdy_s), 64'd0);
    check("rst_rsp_valid", 64'(rv_s), 64'd0);
    check("rst_init", 64'(init_s), 64'd0);
    check("rst_err", 64'(err_s), 64'd0);
    check("rst_comp_data", cdata_s[3] | cdata_s[2] | cdata_s[1] | cdata_s[0], 64'd0);
    req_valid = '0;
    rst = 1'b0;
    step();

    // Single request, latency and one-cycle response.
    offer(0, 64'd3, 64'd4, 64'd1, 64'd2, 1'b1);
    step();
    check("single_ready", 64'(rdy_s), 64'b0001);
    step();
    check("single_init", 64'(init_s), 64'd1);
    check("single_cdata_m", cdata_s[3], 64'd3);
    check("single_cdata_c", cdata_s[0], 64'd2);
    step();
    check("idle_init", 64'(init_s), 64'd0);
    check("idle_cdata", cdata_s[3] | cdata_s[2] | cdata_s[1] | cdata_s[0], 64'd0);
    check("single_early_valid", 64'(rv_s), 64'd0);
    step();
    check("single_valid", 64'(rv_s), 64'b0001);
    check("single_data", rdata_s[0], 64'd10);
    step();
    check("single_valid_drop", 64'(rv_s), 64'd0);
    check("single_data_kept", rdata_s[0], 64'd10);

    // All four at once from P=0: back-to-back grants and results.
    do_reset();
    for (int k = 0; k < int'(N); k++) offer(k, 64'(k + 5), 64'd7, 64'(k), 64'd3, 1'b1);
    for (int j = 0; j < 8; j++) begin
      step();
      e_rdy = (j < 4) ? N'(1 << j) : '0;
      e_rv  = (j >= 3 && j < 7) ? N'(1 << (j - 3)) : '0;
      check($sformatf("rr_ready_c%0d", j), 64'(rdy_s), 64'(e_rdy));
      check($sformatf("rr_valid_c%0d", j), 64'(rv_s), 64'(e_rv));
    end

    // Backpressure on requester 1 with a second request waiting.
    rsp_ready[1] = 1'b0;
    offer(1, 64'd6, 64'd7, 64'd2, 64'd3, 1'b1);
    first_val = 64'd36;
    step();
    check("bp_ready", 64'(rdy_s), 64'b0010);
    offer(1, 64'd9, 64'd9, 64'd0, 64'd0, 1'b1);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp_valid_%0d", i), 64'(rv_s[1]), 64'd1);
      check($sformatf("bp_data_%0d", i), rdata_s[1], first_val);
      check($sformatf("bp_no_grant_%0d", i), 64'(rdy_s[1]), 64'd0);
    end
    rsp_ready[1] = 1'b1;
    step();
    check("bp_consume_no_grant", 64'(rdy_s[1]), 64'd0);
    step();
    check("bp_regrant", 64'(rdy_s[1]), 64'd1);
    drain(5);

    // Modular wrap: 0*0 - 1*1.
    offer(2, 64'd0, 64'd0, 64'd1, 64'd1, 1'b1);
    drain(3);
    step();
    check("wrap_valid", 64'(rv_s[2]), 64'd1);
    check("wrap_data", rdata_s[2], 64'hFFFF_FFFF_FFFF_FFFF);
    drain(2);

    // Spurious completion sets a sticky error.
    check("pre_spur_err", 64'(err_s), 64'd0);
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("spur_err_%0d", i), 64'(err_s), 64'd1);
      check($sformatf("spur_no_valid_%0d", i), 64'(rv_s), 64'd0);
    end

    // Reset clears the error; a missing completion errors and frees the requester.
    do_reset();
    step();
    check("reset_clears_err", 64'(err_s), 64'd0);
    drop_done = 1'b1;
    offer(0, 64'd2, 64'd2, 64'd1, 64'd1, 1'b0);
    step();
    step();
    step();
    drop_done = 1'b0;
    offer(0, 64'd8, 64'd8, 64'd3, 64'd5, 1'b1);
    step();
    check("miss_err", 64'(err_s), 64'd1);
    check("miss_no_valid", 64'(rv_s), 64'd0);
    check("miss_back_idle", 64'(rdy_s), 64'b0001);
    drain(5);

    // Reset right after a grant drops the operation.
    do_reset();
    offer(0, 64'd5, 64'd5, 64'd1, 64'd1, 1'b0);
    step();
    check("inflight_grant", 64'(rdy_s), 64'b0001);
    check("inflight_init_pre", 64'(comp_init), 64'd1);
    rst = 1'b1;
    #1;
    check("inflight_init_rst", 64'(comp_init), 64'd0);
    check("inflight_cdata_rst", comp_data[3], 64'd0);
    check("inflight_rv_rst", 64'(rsp_valid), 64'd0);
    check("inflight_err_rst", 64'(err), 64'd0);
    step();
    step();
    rst = 1'b0;
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("post_rst_rv_%0d", i), 64'(rv_s), 64'd0);
      check($sformatf("post_rst_err_%0d", i), 64'(err_s), 64'd0);
    end

    check("sb_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ame_det_arbiter.md
AME_DET_ARBITER -- requirements
Module: ame_det_arbiter

Interface
REQ-001 Parameter COMP_DATA_BITS, default 64, SHALL set the operand and result width.
REQ-002 Parameter REQ_NUM, default 4, range 2-8, SHALL set the number of requesters.
REQ-003 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 req_valid_i  input  REQ_NUM  SHALL flag, per requester, that a determinant operand set is offered.
REQ-006 req_data_i  input  REQ_NUM x 4 x COMP_DATA_BITS  SHALL carry the per-requester operands, packed {M, D, L, C} with index 3 = M.
REQ-007 req_ready_o  output  REQ_NUM  SHALL flag, per requester, acceptance this cycle; it is combinational and at most one bit is high.
REQ-008 rsp_valid_o  output  REQ_NUM  SHALL flag, per requester, a held result.
REQ-009 rsp_data_o  output  REQ_NUM x COMP_DATA_BITS  SHALL carry the per-requester result.
REQ-010 rsp_ready_i  input  REQ_NUM  SHALL flag, per requester, result consumption.
REQ-011 comp_init_o  output  1  SHALL be a registered start pulse to the shared determinant unit.
REQ-012 comp_data_o  output  4 x COMP_DATA_BITS  SHALL be the registered operands to the unit.
REQ-013 comp_done_i  input  1  SHALL be the unit's completion flag, arriving exactly 1 cycle after comp_init_o.
REQ-014 comp_data_i  input  COMP_DATA_BITS  SHALL be the unit's result, M*D - L*C modulo 2^COMP_DATA_BITS.
REQ-015 err_o  output  1  SHALL be a sticky protocol-error flag.

Function
REQ-016 Each requester k SHALL have its own state machine with states IDLE, BUSY and DONE.
- IDLE -> BUSY on a grant.
- BUSY -> DONE on a tagged comp_done_i.
- DONE -> IDLE on rsp_valid_o[k] & rsp_ready_i[k].
REQ-017 A requester SHALL be eligible only when req_valid_i[k]=1 and its state is IDLE.
REQ-018 Arbitration SHALL be round-robin:
- the search starts at pointer P, wrapping modulo REQ_NUM;
- the first eligible requester is granted;
- after a grant to k, P SHALL become (k+1) mod REQ_NUM;
- P SHALL be unchanged when there is no grant.
REQ-019 On a grant to k in cycle t:
- req_ready_o[k]=1 in cycle t;
- at t+1, comp_init_o=1, comp_data_o=req_data_i[k] sampled at t, and tag k enters stage 1 of a 2-stage valid+tag pipeline.
REQ-020 comp_init_o SHALL be 0 and comp_data_o SHALL be zero in any cycle following a no-grant cycle.
REQ-021 When comp_done_i=1 and stage 2 is valid with tag k:
- comp_data_i SHALL be captured into rsp_data_o[k];
- rsp_valid_o[k]=1 from the next cycle, giving grant-to-valid latency 3 cycles.
REQ-022 rsp_valid_o[k] and rsp_data_o[k] SHALL hold stable until consumed; after consumption rsp_data_o[k] SHALL keep its value.
REQ-023 Sustained throughput SHALL be one grant per cycle when distinct requesters are eligible; each requester SHALL have at most one operation outstanding.
REQ-024 A requester in DONE that is consumed in cycle t SHALL first be eligible in cycle t+1.
REQ-025 comp_done_i=1 with stage 2 invalid SHALL set err_o, and the data SHALL be discarded.
REQ-026 Stage 2 valid with comp_done_i=0 SHALL set err_o, and requester k SHALL return to IDLE without rsp_valid_o.
REQ-027 err_o SHALL clear only on reset.
REQ-028 A simultaneous grant and completion in the same cycle SHALL both take effect.
REQ-029 No arithmetic SHALL be performed in this block; results SHALL pass through unmodified.

Reset
REQ-030 While rst_i=1, regardless of clock, the following SHALL all be forced low or zero: all states (IDLE), P, both pipeline stages, req_ready_o, rsp_valid_o, rsp_data_o, comp_init_o, comp_data_o and err_o.
REQ-031 Operations in flight at reset SHALL be dropped, and comp_done_i SHALL be ignored in the first cycle after reset release without setting err_o.

Verification
REQ-032 Single request: req 0 with M=3, D=4, L=1, C=2 at cycle t, rsp_ready held 1 -> req_ready_o[0]=1 at t; comp_init_o=1 at t+1; rsp_valid_o[0]=1 with data 10 at t+3, for one cycle.
REQ-033 All 4 requesters valid at t with P=0 -> grants to 0, 1, 2, 3 at t..t+3; rsp_valid_o[0..3] at t+3..t+6.
REQ-034 Backpressure: rsp_ready_i[1]=0 for 10 cycles after result -> rsp_valid_o[1] and rsp_data_o[1] stable, no new grant to 1 while req_valid_i[1]=1; grant to 1 on the cycle after consumption.
REQ-035 Wrap: M=0, D=0, L=1, C=1 -> rsp_data_o = all ones (2^64 - 1).
REQ-036 Spurious comp_done_i=1 with no outstanding grant -> err_o=1 next cycle and stays 1; no rsp_valid_o.
REQ-037 rst_i asserted at t+1 after a grant at t -> all outputs 0 immediately; no rsp_valid_o afterwards, and err_o remains 0.
